// File: rtl/reg_write_queue.sv
// Write-request FIFO feeding the 2-to-4 register-write demux with a registered sel/en/data triple.
// Optional REGQ_COALESCE_EN merges a push into the youngest stored entry when the addresses match.
module reg_write_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_addr,
    input  logic [DATA_W-1:0]        req_data,
    input  logic                     wr_stall,
    output logic                     wr_en,
    output logic [1:0]               wr_sel,
    output logic [DATA_W-1:0]        wr_data,
    output logic [$clog2(DEPTH):0]   count
);

    // state | meaning
    // IDLE  | nothing issued at the last edge (queue empty or consumer stalled)
    // ISSUE | head entry popped into the output register at the last edge
    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_W + 2;

    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     mem_d [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    state_t            state_q, state_d;

    logic pop, push, alloc, coal_hit, not_full;

`ifdef REGQ_COALESCE_EN
    logic [PW-1:0] youngest;
    assign youngest = tail_q - PW'(1);
    // The youngest entry cannot be merged into while it is leaving as the head.
    assign coal_hit = (count_q != '0)
                   && (mem_q[youngest][EW-1 -: 2] == req_addr)
                   && !(pop && (count_q == CW'(1)));
`else
    assign coal_hit = 1'b0;
`endif

    always_comb begin
        not_full  = count_q < CW'(DEPTH);
        pop       = (count_q != '0) && !wr_stall;
        state_d   = pop ? ISSUE : IDLE;
        req_ready = not_full || coal_hit;
        push      = req_valid && req_ready;
        alloc     = push && !coal_hit;

        mem_d = mem_q;
        if (push) begin
`ifdef REGQ_COALESCE_EN
            if (coal_hit) mem_d[youngest] = {req_addr, req_data};
            else          mem_d[tail_q]   = {req_addr, req_data};
`else
            mem_d[tail_q] = {req_addr, req_data};
`endif
        end

        head_d  = pop   ? head_q + PW'(1) : head_q;
        tail_d  = alloc ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(alloc) - CW'(pop);

        sel_d  = sel_q;
        data_d = data_q;
        if (pop) {sel_d, data_d} = mem_q[head_q];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            state_q <= IDLE;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            state_q <= state_d;
        end
    end

    assign wr_en   = (state_q == ISSUE);
    assign wr_sel  = sel_q;
    assign wr_data = data_q;
    assign count   = count_q;

endmodule

// File: tb/tb_reg_write_queue.sv
// Bench for reg_write_queue: fixed vector table, directed corner sequences and a queue-model random run.
module tb_reg_write_queue;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
`ifdef REGQ_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_addr = '0;
    logic [DATA_W-1:0] req_data = '0;
    logic              wr_stall = 1'b0;
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        count;

    reg_write_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .wr_stall  (wr_stall),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
    } ent_t;

    ent_t       mq[$];
    logic [1:0] m_sel;
    logic [7:0] m_data;

    typedef struct {
        bit       v;
        bit [1:0] a;
        bit [7:0] d;
        bit       s;
        bit       rdy;
        bit       en;
        bit [1:0] sel;
        bit [7:0] dat;
        int       cnt;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit [1:0] a, input bit [7:0] d, input bit s);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        wr_stall  = s;
    endtask

    // Called at a falling edge; returns at a falling edge with the queue and outputs cleared.
    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_sel", wr_sel, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_count", count, 0);
        chk("rst_req_ready", req_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        mq.delete();
        m_sel  = '0;
        m_data = '0;
    endtask

    // One clock of stimulus checked against the queue model.
    task automatic mstep(input bit v, input bit [1:0] a, input bit [7:0] d, input bit s);
        int   sz;
        bit   pop, hit, rdy, push;
        ent_t e;
        sz   = mq.size();
        pop  = (sz > 0) && !s;
        hit  = COAL && (sz > 0) && (mq[sz-1].addr == a) && !(pop && sz == 1);
        rdy  = (sz < DEPTH) || hit;
        push = v && rdy;
        drive(v, a, d, s);
        #1;
        chk("m_req_ready", req_ready, rdy);
        if (push && hit) mq[sz-1].data = d;
        if (pop) begin
            e      = mq.pop_front();
            m_sel  = e.addr;
            m_data = e.data;
        end
        if (push && !hit) mq.push_back('{addr: a, data: d});
        @(posedge clk);
        @(negedge clk);
        chk("m_wr_en", wr_en, pop);
        chk("m_wr_sel", wr_sel, m_sel);
        chk("m_wr_data", wr_data, m_data);
        chk("m_count", count, mq.size());
    endtask

    initial begin
        tbl[0]  = '{1, 2, 8'hA5, 0, 1, 0, 0, 8'h00, 1};
        tbl[1]  = '{0, 0, 8'h00, 0, 1, 1, 2, 8'hA5, 0};
        tbl[2]  = '{0, 0, 8'h00, 0, 1, 0, 2, 8'hA5, 0};
        tbl[3]  = '{1, 0, 8'h10, 1, 1, 0, 2, 8'hA5, 1};
        tbl[4]  = '{1, 1, 8'h11, 1, 1, 0, 2, 8'hA5, 2};
        tbl[5]  = '{1, 2, 8'h12, 1, 1, 0, 2, 8'hA5, 3};
        tbl[6]  = '{1, 3, 8'h13, 1, 1, 0, 2, 8'hA5, 4};
        tbl[7]  = '{1, 0, 8'h14, 1, 0, 0, 2, 8'hA5, 4};
        tbl[8]  = '{1, 0, 8'h14, 0, 0, 1, 0, 8'h10, 3};
        tbl[9]  = '{1, 0, 8'h14, 0, 1, 1, 1, 8'h11, 3};
        tbl[10] = '{0, 0, 8'h00, 0, 1, 1, 2, 8'h12, 2};
        tbl[11] = '{0, 0, 8'h00, 0, 1, 1, 3, 8'h13, 1};
        tbl[12] = '{0, 0, 8'h00, 0, 1, 1, 0, 8'h14, 0};
        tbl[13] = '{0, 0, 8'h00, 0, 1, 0, 0, 8'h14, 0};

        #2;
        @(negedge clk);
        do_reset();

        // Vector table: single issue latency, then a stalled fill past full and an ordered drain.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].s);
            #1;
            chk($sformatf("t%0d_ready", i), req_ready, tbl[i].rdy);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("t%0d_wr_en", i), wr_en, tbl[i].en);
            chk($sformatf("t%0d_wr_sel", i), wr_sel, tbl[i].sel);
            chk($sformatf("t%0d_wr_data", i), wr_data, tbl[i].dat);
            chk($sformatf("t%0d_count", i), count, tbl[i].cnt);
        end

        // Sustained push+pop at constant occupancy across pointer wrap.
        do_reset();
        mstep(1, 0, 8'h40, 1);
        mstep(1, 1, 8'h41, 1);
        for (int i = 0; i < 10; i++) begin
            mstep(1, 2'((i + 2) % 4), 8'(8'h42 + i), 0);
            chk("pp_count", count, 2);
            chk("pp_wr_en", wr_en, 1);
            chk("pp_wr_data", wr_data, 8'h40 + i);
        end

        // Three stalled cycles mid-stream.
        do_reset();
        mstep(1, 0, 8'h50, 0);
        mstep(1, 1, 8'h51, 0);
        chk("st_first", wr_data, 8'h50);
        mstep(1, 2, 8'h52, 1);
        chk("st_en0", wr_en, 0);
        mstep(1, 3, 8'h53, 1);
        chk("st_en1", wr_en, 0);
        mstep(0, 0, 8'h00, 1);
        chk("st_en2", wr_en, 0);
        chk("st_count", count, 3);
        for (int i = 0; i < 3; i++) begin
            mstep(0, 0, 8'h00, 0);
            chk("st_drain_en", wr_en, 1);
            chk("st_drain_data", wr_data, 8'h51 + i);
        end

        // Asynchronous reset in the middle of a burst.
        do_reset();
        mstep(1, 3, 8'h5A, 0);
        mstep(0, 0, 8'h00, 0);
        chk("mb_sel_pre", wr_sel, 3);
        mstep(1, 0, 8'h01, 1);
        mstep(1, 1, 8'h02, 1);
        mstep(1, 2, 8'h03, 1);
        chk("mb_count_pre", count, 3);
        do_reset();
        mstep(1, 1, 8'h77, 0);
        mstep(0, 0, 8'h00, 0);
        chk("mb_post_en", wr_en, 1);
        chk("mb_post_sel", wr_sel, 1);
        chk("mb_post_data", wr_data, 8'h77);
        chk("mb_post_count", count, 0);

        // Same-address pushes behind a stall.
        do_reset();
        mstep(1, 1, 8'h11, 1);
        mstep(1, 1, 8'h22, 1);
`ifdef REGQ_COALESCE_EN
        chk("co_count", count, 1);
        mstep(0, 0, 8'h00, 0);
        chk("co_issue_data", wr_data, 8'h22);
        mstep(0, 0, 8'h00, 0);
        chk("co_no_second", wr_en, 0);
`else
        chk("co_count", count, 2);
        mstep(0, 0, 8'h00, 0);
        chk("co_issue_data", wr_data, 8'h11);
        mstep(0, 0, 8'h00, 0);
        chk("co_second_en", wr_en, 1);
        chk("co_second_data", wr_data, 8'h22);
`endif

        // Randomized traffic against the queue model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            mstep($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
